jericalla_evolucion: RTL and testbench

//  Single-cycle datapath: 32x32 register file, ALU and 32-word data RAM, driven by a 19-bit instruction.

---
 rtl/jericalla_evolucion.sv | 187 ++++++++++++++++++
 tb/tb_jericalla_evolucion.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/jericalla_evolucion.sv
// rtl/jericalla_evolucion.sv - single-cycle jericalla datapath: register file, ALU and data RAM
//
// Purpose:
//   Executes one 19-bit instruction on every rising clk edge.
//   ALU results and loads are written back to the register file.
//   SW writes to the data RAM.
//   data_out/zf hold the result of the last executed instruction.
//
// Ports (jericalla_evolucion):
//   clk          in   1   single clock; all state changes on the rising edge
//   reset        in   1   synchronous, active-high; clears data_out/zf only
//   instruction  in   19  [18:15] opcode, [14:10] rd, [9:5] rs1, [4:0] rs2
//   data_out     out  32  registered result R
//   zf           out  1   registered (R == 0)
//
// Ports (banco_de_registros):
//   clk          in   1   write clock
//   we           in   1   write enable
//   waddr        in   AW  write address
//   wdata        in   DW  write data
//   raddr1/2     in   AW  combinational read addresses
//   rdata1/2     out  DW  combinational read data

module banco_de_registros #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_AW     = 5
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [REG_AW-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [REG_AW-1:0]     raddr1,
  input  logic [REG_AW-1:0]     raddr2,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [DATA_WIDTH-1:0] rdata2
);

  // No reset: contents are preloaded externally and survive reset.
  logic [DATA_WIDTH-1:0] mem [0:(1<<REG_AW)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata1 = mem[raddr1];
  assign rdata2 = mem[raddr2];

endmodule

module jericalla_evolucion #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_AW     = 5,
  parameter int RAM_AW     = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [18:0]           instruction,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  zf
);

  typedef enum logic [3:0] {
    OP_NOP = 4'b0000,
    OP_AND = 4'b0001,
    OP_ADD = 4'b0010,
    OP_SUB = 4'b0011,
    OP_SLT = 4'b0100,
    OP_OR  = 4'b0101,
    OP_SW  = 4'b0110,
    OP_LW  = 4'b0111
  } opcode_e;

  logic [3:0]        opcode;
  logic [REG_AW-1:0] rd;
  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rs2;

  assign opcode = instruction[18:15];
  assign rd     = instruction[14:10];
  assign rs1    = instruction[9:5];
  assign rs2    = instruction[4:0];

  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic [DATA_WIDTH-1:0] result;
  logic                  reg_we;
  logic                  ram_we;
  logic [RAM_AW-1:0]     ram_addr;
  logic [DATA_WIDTH-1:0] ram_rdata;

  logic [DATA_WIDTH-1:0] data_out_q;
  logic [DATA_WIDTH-1:0] data_out_d;
  logic                  zf_q;
  logic                  zf_d;

  // Data RAM: synchronous write, combinational read, never cleared.
  logic [DATA_WIDTH-1:0] ram_mem [0:(1<<RAM_AW)-1];

  banco_de_registros #(
    .DATA_WIDTH (DATA_WIDTH),
    .REG_AW     (REG_AW)
  ) banco_de_registros_inst (
    .clk    (clk),
    .we     (reg_we),
    .waddr  (rd),
    .wdata  (result),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (op_a),
    .rdata2 (op_b)
  );

  // The RAM is addressed by the low bits of rs1's value for both SW and LW.
  assign ram_addr  = op_a[RAM_AW-1:0];
  assign ram_rdata = ram_mem[ram_addr];

  always_comb begin
    result = '0;
    reg_we = 1'b0;
    ram_we = 1'b0;
    unique case (opcode)
      OP_AND: begin
        result = op_a & op_b;
        reg_we = 1'b1;
      end
      OP_ADD: begin
        result = op_a + op_b;
        reg_we = 1'b1;
      end
      OP_SUB: begin
        result = op_a - op_b;
        reg_we = 1'b1;
      end
      OP_SLT: begin
        result = {{(DATA_WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
        reg_we = 1'b1;
      end
      OP_OR: begin
        result = op_a | op_b;
        reg_we = 1'b1;
      end
      OP_SW: begin
        // rd is a don't-care here; reg_we stays low so an undefined rd cannot write.
        result = op_b;
        ram_we = 1'b1;
      end
      OP_LW: begin
        result = ram_rdata;
        reg_we = 1'b1;
      end
      default: begin
        result = '0;
      end
    endcase
    // Reset aborts this cycle's writes without touching stored contents.
    if (reset) begin
      reg_we = 1'b0;
      ram_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram_mem[ram_addr] <= op_b;
    end
  end

  always_comb begin
    data_out_d = result;
    zf_d       = (result == '0);
    if (reset) begin
      data_out_d = '0;
      zf_d       = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    data_out_q <= data_out_d;
    zf_q       <= zf_d;
  end

  assign data_out = data_out_q;
  assign zf       = zf_q;

endmodule

// File: tb/tb_jericalla_evolucion.sv
// tb/tb_jericalla_evolucion.sv - directed self-checking bench for jericalla_evolucion

module tb_jericalla_evolucion;

  logic        clk;
  logic        reset;
  logic [18:0] instruction;
  logic [31:0] data_out;
  logic        zf;

  int compared;
  int mismatched;

  jericalla_evolucion dut (
    .clk         (clk),
    .reset       (reset),
    .instruction (instruction),
    .data_out    (data_out),
    .zf          (zf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s: observed %0d (0x%08h) expected %0d (0x%08h)", tag, observed, observed, expected, expected);
    end
  endtask

  task automatic exec(input logic [18:0] instr);
    instruction = instr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;

    dut.banco_de_registros_inst.mem[0]  = 32'd222;
    dut.banco_de_registros_inst.mem[1]  = 32'd111;
    dut.banco_de_registros_inst.mem[2]  = 32'd100;
    dut.banco_de_registros_inst.mem[3]  = 32'd200;
    dut.banco_de_registros_inst.mem[4]  = 32'd5;
    dut.banco_de_registros_inst.mem[7]  = 32'd20;
    dut.banco_de_registros_inst.mem[8]  = 32'd0;
    dut.banco_de_registros_inst.mem[10] = 32'hFFFF_FFFF;
    dut.banco_de_registros_inst.mem[11] = 32'd1;
    dut.banco_de_registros_inst.mem[13] = 32'd7;
    dut.banco_de_registros_inst.mem[15] = 32'd9;

    // Reset for 3 cycles while an ADD r4 is presented: no write may happen.
    reset       = 1'b1;
    instruction = 19'b0010_00100_00000_00001;
    repeat (3) @(posedge clk);
    #1;
    check("reset_data_out", data_out, 32'd0);
    check("reset_zf", {31'b0, zf}, 32'd1);
    check("reset_r0_kept", dut.banco_de_registros_inst.mem[0], 32'd222);
    check("reset_r1_kept", dut.banco_de_registros_inst.mem[1], 32'd111);
    check("reset_r4_no_write", dut.banco_de_registros_inst.mem[4], 32'd5);
    reset = 1'b0;

    exec(19'b0010_00100_00000_00001);           // ADD r4 = 222 + 111
    check("add_data_out", data_out, 32'd333);
    check("add_zf", {31'b0, zf}, 32'd0);
    check("add_r4", dut.banco_de_registros_inst.mem[4], 32'd333);

    exec(19'b0011_00101_00001_00010);           // SUB r5 = 111 - 100
    check("sub_data_out", data_out, 32'd11);
    check("sub_r5", dut.banco_de_registros_inst.mem[5], 32'd11);

    exec(19'b0011_01110_00001_00001);           // SUB r14 = r1 - r1
    check("sub_self_data_out", data_out, 32'd0);
    check("sub_self_zf", {31'b0, zf}, 32'd1);

    exec(19'b0100_00110_00010_00011);           // SLT r6 = 100 < 200
    check("slt_data_out", data_out, 32'd1);
    check("slt_r6", dut.banco_de_registros_inst.mem[6], 32'd1);

    exec(19'b0100_00110_00011_00010);           // SLT r6 = 200 < 100
    check("slt_swap_data_out", data_out, 32'd0);
    check("slt_swap_zf", {31'b0, zf}, 32'd1);

    exec(19'b0100_01100_01010_01011);           // SLT r12 = -1 < 1 signed
    check("slt_signed_data_out", data_out, 32'd1);

    exec(19'b0001_01001_00100_00011);           // AND r9 = 333 & 200 = 72
    check("and_data_out", data_out, 32'd72);

    exec(19'b0101_01001_00100_00011);           // OR r9 = 333 | 200 = 461
    check("or_data_out", data_out, 32'd461);

    exec(19'b0110_00000_00111_00100);           // SW RAM[r7=20] = r4 = 333, rd field = r0
    check("sw_data_out", data_out, 32'd333);
    check("sw_ram20", dut.ram_mem[20], 32'd333);
    check("sw_r0_untouched", dut.banco_de_registros_inst.mem[0], 32'd222);

    exec(19'b0111_01000_00111_00000);           // LW r8 = RAM[r7=20]
    check("lw_data_out", data_out, 32'd333);
    check("lw_r8", dut.banco_de_registros_inst.mem[8], 32'd333);

    exec(19'b0010_01101_01010_01011);           // ADD r13 = 0xFFFFFFFF + 1
    check("add_wrap_data_out", data_out, 32'd0);
    check("add_wrap_zf", {31'b0, zf}, 32'd1);
    check("add_wrap_r13", dut.banco_de_registros_inst.mem[13], 32'd0);

    exec(19'b1111_00100_00001_00010);           // reserved opcode acts as NOP
    check("op1111_data_out", data_out, 32'd0);
    check("op1111_zf", {31'b0, zf}, 32'd1);
    check("op1111_r4_kept", dut.banco_de_registros_inst.mem[4], 32'd333);
    check("op1111_ram20_kept", dut.ram_mem[20], 32'd333);

    exec(19'b0000_00100_00001_00010);           // NOP
    check("nop_data_out", data_out, 32'd0);
    check("nop_r4_kept", dut.banco_de_registros_inst.mem[4], 32'd333);

    exec(19'b0010_00001_00001_00001);           // ADD r1 = r1 + r1 (111 -> 222)
    check("raw1_data_out", data_out, 32'd222);
    exec(19'b0010_00001_00001_00001);           // re-executes on new value (222 -> 444)
    check("raw2_data_out", data_out, 32'd444);
    check("raw2_r1", dut.banco_de_registros_inst.mem[1], 32'd444);

    reset = 1'b1;
    exec(19'b0010_01111_00000_00000);           // ADD r15 aborted by reset
    check("midreset_data_out", data_out, 32'd0);
    check("midreset_zf", {31'b0, zf}, 32'd1);
    check("midreset_r15_kept", dut.banco_de_registros_inst.mem[15], 32'd9);
    reset = 1'b0;

    exec(19'b0010_01111_00000_00000);           // same ADD after reset: 222 + 222
    check("postreset_data_out", data_out, 32'd444);
    check("postreset_r15", dut.banco_de_registros_inst.mem[15], 32'd444);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
